sysbus_mem_responder: RTL and testbench
=======================================

Name: sysbus_mem_responder

Overview:
- Memory-side target of the CPU SysBus memory protocol (ALE / nME / nOE / nWE strobes on a multiplexed 16-bit address/data bus).
- Latches the address on ALE, decodes a hit against a base window, and services reads by driving data back.
- Services writes by capturing bus data into an internal synchronous RAM.
- Sits between the SysBus pads and on-chip RAM; used as the program/data memory model and as the synthesizable scratch RAM.

Parameters:
- DATA_WIDTH, 16, SysBus width (address and data share the bus).
- DEPTH_LOG2, 10, log2 of RAM depth in words.
- BASE_ADDR, 16'h0000, first word address of the decode window; must be aligned to 2**DEPTH_LOG2.

Ports:
- Clock  input  1  system clock, all state on posedge.
- nReset  input  1  synchronous, active-low reset.
- SysBusIn  input  DATA_WIDTH  bus value from the pads (address while ALE, write data while nWE low).
- SysBusOut  output  DATA_WIDTH  read data to the pads.
- SysBusOe  output  1  pad output enable for SysBusOut.
- ALE  input  1  address latch enable, active high.
- nME  input  1  memory enable, active low.
- nOE  input  1  output (read) enable, active low.
- nWE  input  1  write enable, active low.
- Busy  output  1  high while in ADDR, READ or WRITE.
- AccessErr  output  1  one-cycle pulse when a read/write strobe arrives for a miss.

Behaviour:
- Interface: one clock (Clock); nReset is synchronous and active-low. Strobes are sampled on posedge Clock only; no combinational path from any input to any output.
- Reset (nReset sampled low):
  - state=IDLE, SysBusOe=0, SysBusOut=0, latched Addr=0, Hit=0, AccessErr=0, Busy=0.
  - RAM contents are not reset.
  - Reset mid-cycle releases the bus on the following cycle.
- Hit: Addr[DATA_WIDTH-1:DEPTH_LOG2] == BASE_ADDR[DATA_WIDTH-1:DEPTH_LOG2]. RAM index is Addr[DEPTH_LOG2-1:0].
- Read strobe: nME=0, nOE=0, nWE=1. Write strobe: nME=0, nWE=0, nOE=1. nME=0 with both nOE and nWE high (or both low) is a null cycle.
- States are IDLE, ADDR, READ and WRITE. ALE sampled high has top priority in every state: latch Addr<=SysBusIn, compute Hit, go to ADDR, SysBusOe<=0. An in-flight read is aborted with no RAM side effect.
- IDLE:
  - Stays put unless ALE.
  - Strobes without a preceding ALE are ignored (no error).
- ADDR:
  - Read strobe with Hit: RAM read issued; next state READ; SysBusOut/SysBusOe valid from the next cycle (1-cycle latency after the strobe edge).
  - Write strobe with Hit: RAM[index]<=SysBusIn on that edge; next state WRITE.
  - Any strobe with miss: AccessErr=1 for one cycle, go to IDLE, bus never driven.
  - nME=1 or null cycle: remain in ADDR, with unlimited hold.
- READ:
  - SysBusOe=1, SysBusOut holds the read word.
  - Remain while the read strobe stays sampled. When nME or nOE is sampled high, go to IDLE; SysBusOe=0 in the next cycle.
  - Result: data is driven through the CPU's ENB and IR/register latch cycles and released before the next ALE cycle.
- WRITE:
  - No further RAM writes, even if nWE stays low.
  - Return to IDLE when nME is sampled high or nWE is sampled high.
  - Exactly one RAM write per address phase.
- SysBusOe is never 1 in a cycle where ALE is sampled or the write strobe is active. This is an assertion for the bench.
- AccessErr is registered, high for exactly one cycle per offending strobe.

Decomposition:
- Shared package mem_bus:
  - responder state enum (IDLE, ADDR, READ, WRITE);
  - strobe decode constants/functions (is_read, is_write);
  - default BASE_ADDR/DEPTH_LOG2 for the system memory map.
- Sub-module sysbus_ram: single-port synchronous RAM, registered read, write-first not required (reads and writes never coincide), parameters DATA_WIDTH and DEPTH_LOG2.

Test Plan:
1. Write then read-back:
   - Write: ALE with 0x0012; null cycle; write strobe with SysBusIn=0xBEEF; nME=1.
   - Read: ALE 0x0012; read strobe for 2 cycles; nME=1.
   - Expected: SysBusOe=1 for exactly 2 cycles starting one cycle after the first read strobe, SysBusOut=0xBEEF, SysBusOe=0 after nME=1.
2. Miss: BASE_ADDR=0x0000, ALE 0x0400, read strobe -> AccessErr pulses one cycle, SysBusOe stays 0, state IDLE; a write strobe to 0x0400 leaves RAM[0] unchanged.
3. Held write:
   - Stimulus: ALE 0x0003; write strobe 0x1111 with nWE held low for 3 cycles while SysBusIn changes to 0x2222.
   - Expected: RAM[3]=0x1111; single write only.
4. ALE abort: read started at 0x0005 (data 0xA5A5); ALE 0x0006 sampled during READ -> SysBusOe=0 the next cycle; subsequent read returns RAM[6].
5. Reset mid-read: nReset low while in READ -> SysBusOe=0, Busy=0, SysBusOut=0 the next cycle; RAM contents preserved on a later read.
6. Back-to-back full CPU sequences (4-cycle fetch, 5-cycle LDW/STW pattern) at 0x0000..0x000F -> all data correct, bus-contention assertion never fires.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the SysBus memory responder.
// Contents:
//   resp_state_t         responder FSM state encoding
//   is_read / is_write   strobe decode from the active-low nME/nOE/nWE lines
//   SYS_*                default data width and memory map for the system memory
package mem_bus;

  localparam int unsigned SYS_DATA_WIDTH = 16;
  localparam int unsigned SYS_DEPTH_LOG2 = 10;
  localparam logic [SYS_DATA_WIDTH-1:0] SYS_BASE_ADDR = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_READ  = 2'd2,
    ST_WRITE = 2'd3
  } resp_state_t;

  // Read strobe: memory selected, output enable low, write enable high.
  function automatic logic is_read(input logic nme, input logic noe, input logic nwe);
    return !nme && !noe && nwe;
  endfunction

  // Write strobe: memory selected, write enable low, output enable high.
  // nOE and nWE both low is a null cycle, not a write.
  function automatic logic is_write(input logic nme, input logic noe, input logic nwe);
    return !nme && noe && !nwe;
  endfunction

endpackage

// File: rtl/sysbus_ram.sv
// Single-port synchronous RAM with a registered read port.
// Ports:
//   clk    system clock
//   we     write enable, mem[addr] <= wdata on the edge
//   re     read enable, rdata <= mem[addr] on the edge; rdata holds otherwise
//   addr   word index
//   wdata  write data
//   rdata  registered read data
// Reads and writes are never requested together, so no write-first behaviour.
module sysbus_ram #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/sysbus_mem_responder.sv
// Memory-side target of the CPU SysBus protocol (multiplexed address/data bus
// with ALE / nME / nOE / nWE strobes) backed by an on-chip synchronous RAM.
// Ports:
//   Clock      system clock, all state on posedge
//   nReset     synchronous active-low reset
//   SysBusIn   bus value from the pads (address while ALE, data while writing)
//   SysBusOut  read data to the pads (zero whenever the bus is not driven)
//   SysBusOe   pad output enable
//   ALE        address latch enable, active high
//   nME        memory enable, active low
//   nOE        read enable, active low
//   nWE        write enable, active low
//   Busy       high while in ADDR, READ or WRITE
//   AccessErr  one-cycle pulse when a read/write strobe targets a miss
//   StateDbg   current FSM state
//   AddrDbg    latched address
// Handshake: every input is sampled on posedge Clock only. ALE sampled high
// wins in every state. After an address phase, exactly one strobe is acted
// on: a hit read drives the bus from the next cycle until nME or nOE is
// sampled high; a hit write stores one word; a miss strobe raises AccessErr.
module sysbus_mem_responder
  import mem_bus::*;
#(
  parameter int unsigned           DATA_WIDTH = SYS_DATA_WIDTH,
  parameter int unsigned           DEPTH_LOG2 = SYS_DEPTH_LOG2,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = DATA_WIDTH'(SYS_BASE_ADDR)
) (
  input  logic                  Clock,
  input  logic                  nReset,
  input  logic [DATA_WIDTH-1:0] SysBusIn,
  output logic [DATA_WIDTH-1:0] SysBusOut,
  output logic                  SysBusOe,
  input  logic                  ALE,
  input  logic                  nME,
  input  logic                  nOE,
  input  logic                  nWE,
  output logic                  Busy,
  output logic                  AccessErr,
  output resp_state_t           StateDbg,
  output logic [DATA_WIDTH-1:0] AddrDbg
);

  resp_state_t           state;
  logic [DATA_WIDTH-1:0] addr;
  logic                  hit;
  logic                  oe;
  logic                  err;

  logic                  rd_strobe;
  logic                  wr_strobe;
  logic                  hit_next;
  logic                  ram_we;
  logic                  ram_re;
  logic [DATA_WIDTH-1:0] ram_q;

  assign rd_strobe = is_read(nME, nOE, nWE);
  assign wr_strobe = is_write(nME, nOE, nWE);
  assign hit_next  = (SysBusIn[DATA_WIDTH-1:DEPTH_LOG2] == BASE_ADDR[DATA_WIDTH-1:DEPTH_LOG2]);

  // RAM is touched only on the strobe edge out of ADDR; ALE or reset on the
  // same edge cancels the access so an aborted phase has no side effect.
  assign ram_we = nReset && !ALE && (state == ST_ADDR) && hit && wr_strobe;
  assign ram_re = nReset && !ALE && (state == ST_ADDR) && hit && rd_strobe;

  sysbus_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk  (Clock),
    .we   (ram_we),
    .re   (ram_re),
    .addr (addr[DEPTH_LOG2-1:0]),
    .wdata(SysBusIn),
    .rdata(ram_q)
  );

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      state <= ST_IDLE;
      addr  <= '0;
      hit   <= 1'b0;
      oe    <= 1'b0;
      err   <= 1'b0;
    end else begin
      err <= 1'b0;
      if (ALE) begin
        addr  <= SysBusIn;
        hit   <= hit_next;
        state <= ST_ADDR;
        oe    <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            // Strobes without an address phase are ignored.
          end
          ST_ADDR: begin
            if (rd_strobe || wr_strobe) begin
              if (!hit) begin
                err   <= 1'b1;
                state <= ST_IDLE;
              end else if (rd_strobe) begin
                // RAM read is issued on this edge, so data and enable line up.
                state <= ST_READ;
                oe    <= 1'b1;
              end else begin
                state <= ST_WRITE;
              end
            end
          end
          ST_READ: begin
            if (nME || nOE) begin
              state <= ST_IDLE;
              oe    <= 1'b0;
            end
          end
          ST_WRITE: begin
            if (nME || nWE) begin
              state <= ST_IDLE;
            end
          end
          default: begin
            state <= ST_IDLE;
            oe    <= 1'b0;
          end
        endcase
      end
    end
  end

  // The RAM read register is not reset, so the pad data is gated by the
  // enable; this also forces SysBusOut to zero straight after reset.
  assign SysBusOut = oe ? ram_q : '0;
  assign SysBusOe  = oe;
  assign Busy      = (state != ST_IDLE);
  assign AccessErr = err;
  assign StateDbg  = state;
  assign AddrDbg   = addr;

endmodule

// File: tb/tb_sysbus_mem_responder.sv
module tb_sysbus_mem_responder;
  import mem_bus::*;

  logic        Clock;
  logic        nReset;
  logic [15:0] SysBusIn;
  logic [15:0] SysBusOut;
  logic        SysBusOe;
  logic        ALE;
  logic        nME;
  logic        nOE;
  logic        nWE;
  logic        Busy;
  logic        AccessErr;
  resp_state_t StateDbg;
  logic [15:0] AddrDbg;

  int n_tests = 0;
  int n_fail  = 0;
  bit strict_mon = 1'b0;

  sysbus_mem_responder #(
    .DATA_WIDTH(16),
    .DEPTH_LOG2(10),
    .BASE_ADDR (16'h0000)
  ) dut (
    .Clock    (Clock),
    .nReset   (nReset),
    .SysBusIn (SysBusIn),
    .SysBusOut(SysBusOut),
    .SysBusOe (SysBusOe),
    .ALE      (ALE),
    .nME      (nME),
    .nOE      (nOE),
    .nWE      (nWE),
    .Busy     (Busy),
    .AccessErr(AccessErr),
    .StateDbg (StateDbg),
    .AddrDbg  (AddrDbg)
  );

  // ---------------- clock / reset ----------------
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // ---------------- bus contention monitor ----------------
  // After any edge that sampled ALE or a write strobe the bus must be released.
  // In strict mode (well-formed CPU sequences) the bus must already be
  // released while ALE is on the pads.
  always @(posedge Clock) begin
    logic pre_oe, s_ale, s_wr;
    pre_oe = SysBusOe;
    s_ale  = ALE;
    s_wr   = !nME && !nWE && nOE;
    #1;
    if (nReset && (s_ale || s_wr)) begin
      n_tests++;
      if (SysBusOe !== 1'b0) begin
        n_fail++;
        $display("FAIL contention_after_edge: SysBusOe=%b required 0", SysBusOe);
      end
    end
    if (strict_mon && s_ale) begin
      n_tests++;
      if (pre_oe !== 1'b0) begin
        n_fail++;
        $display("FAIL contention_during_ale: SysBusOe=%b required 0", pre_oe);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic ale, input logic nme, input logic noe,
                     input logic nwe, input logic [15:0] din);
    ALE = ale; nME = nme; nOE = noe; nWE = nwe; SysBusIn = din;
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string name, input logic oe, input logic [15:0] dout,
                     input logic busy, input logic err);
    n_tests++;
    if (SysBusOe !== oe || SysBusOut !== dout || Busy !== busy || AccessErr !== err) begin
      n_fail++;
      $display("FAIL %s: oe/out/busy/err=%b/%h/%b/%b required %b/%h/%b/%b",
               name, SysBusOe, SysBusOut, Busy, AccessErr, oe, dout, busy, err);
    end
  endtask

  task automatic chk_state(input string name, input resp_state_t exp);
    n_tests++;
    if (StateDbg !== exp) begin
      n_fail++;
      $display("FAIL %s: state=%0d required %0d", name, StateDbg, exp);
    end
  endtask

  // 5-cycle store: ALE, null, write, write held, release.
  task automatic stw(input logic [15:0] a, input logic [15:0] d);
    cyc(1, 1, 1, 1, a);           chk("stw_ale", 0, 16'h0, 1, 0);
    cyc(0, 0, 1, 1, 16'h0);       chk("stw_null", 0, 16'h0, 1, 0);
    cyc(0, 0, 1, 0, d);           chk("stw_wr", 0, 16'h0, 1, 0);
    cyc(0, 0, 1, 0, d);           chk("stw_hold", 0, 16'h0, 1, 0);
    cyc(0, 1, 1, 1, 16'h0);       chk("stw_rel", 0, 16'h0, 0, 0);
  endtask

  // 4-cycle fetch: ALE, read, read, release.
  task automatic fetch(input logic [15:0] a, input logic [15:0] d);
    cyc(1, 1, 1, 1, a);           chk("fetch_ale", 0, 16'h0, 1, 0);
    cyc(0, 0, 0, 1, 16'h0);       chk("fetch_rd1", 1, d, 1, 0);
    cyc(0, 0, 0, 1, 16'h0);       chk("fetch_rd2", 1, d, 1, 0);
    cyc(0, 1, 1, 1, 16'h0);       chk("fetch_rel", 0, 16'h0, 0, 0);
  endtask

  // 5-cycle load: ALE, null, read, read, release.
  task automatic ldw(input logic [15:0] a, input logic [15:0] d);
    cyc(1, 1, 1, 1, a);           chk("ldw_ale", 0, 16'h0, 1, 0);
    cyc(0, 0, 1, 1, 16'h0);       chk("ldw_null", 0, 16'h0, 1, 0);
    cyc(0, 0, 0, 1, 16'h0);       chk("ldw_rd1", 1, d, 1, 0);
    cyc(0, 0, 0, 1, 16'h0);       chk("ldw_rd2", 1, d, 1, 0);
    cyc(0, 1, 1, 1, 16'h0);       chk("ldw_rel", 0, 16'h0, 0, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic        ale, nme, noe, nwe;
    logic [15:0] din;
    logic        oe;
    logic [15:0] dout;
    logic        busy, err;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input string name, input logic ale, input logic nme,
                              input logic noe, input logic nwe, input logic [15:0] din,
                              input logic oe, input logic [15:0] dout,
                              input logic busy, input logic err);
    vec_t v;
    v.name = name; v.ale = ale; v.nme = nme; v.noe = noe; v.nwe = nwe; v.din = din;
    v.oe = oe; v.dout = dout; v.busy = busy; v.err = err;
    tbl.push_back(v);
  endfunction

  function automatic logic [15:0] pat(input int i);
    logic [15:0] b;
    b = 16'hC35A;
    return b ^ 16'(i << 4) ^ 16'(i);
  endfunction

  initial begin
    //                  name          ale nme noe nwe din       oe out      busy err
    // write then read-back
    add("t1_ale_w",      1, 1, 1, 1, 16'h0012, 0, 16'h0000, 1, 0);
    add("t1_null",       0, 0, 1, 1, 16'h0000, 0, 16'h0000, 1, 0);
    add("t1_wr",         0, 0, 1, 0, 16'hBEEF, 0, 16'h0000, 1, 0);
    add("t1_wrel",       0, 1, 1, 1, 16'h0000, 0, 16'h0000, 0, 0);
    add("t1_ale_r",      1, 1, 1, 1, 16'h0012, 0, 16'h0000, 1, 0);
    add("t1_rd1",        0, 0, 0, 1, 16'h0000, 1, 16'hBEEF, 1, 0);
    add("t1_rd2",        0, 0, 0, 1, 16'h0000, 1, 16'hBEEF, 1, 0);
    add("t1_rrel",       0, 1, 1, 1, 16'h0000, 0, 16'h0000, 0, 0);
    // strobe without address phase is ignored
    add("idle_rd",       0, 0, 0, 1, 16'h0000, 0, 16'h0000, 0, 0);
    add("idle_rel",      0, 1, 1, 1, 16'h0000, 0, 16'h0000, 0, 0);
    // seed RAM[0], then miss at 0x0400
    add("t2_ale0",       1, 1, 1, 1, 16'h0000, 0, 16'h0000, 1, 0);
    add("t2_wr0",        0, 0, 1, 0, 16'h0A0A, 0, 16'h0000, 1, 0);
    add("t2_rel0",       0, 1, 1, 1, 16'h0000, 0, 16'h0000, 0, 0);
    add("t2_ale_mr",     1, 1, 1, 1, 16'h0400, 0, 16'h0000, 1, 0);
    add("t2_miss_nul",   0, 0, 1, 1, 16'h0000, 0, 16'h0000, 1, 0);
    add("t2_miss_rd",    0, 0, 0, 1, 16'h0000, 0, 16'h0000, 0, 1);
    add("t2_err_end",    0, 0, 0, 1, 16'h0000, 0, 16'h0000, 0, 0);
    add("t2_ale_mw",     1, 1, 1, 1, 16'h0400, 0, 16'h0000, 1, 0);
    add("t2_miss_wr",    0, 0, 1, 0, 16'h1234, 0, 16'h0000, 0, 1);
    add("t2_err_end2",   0, 1, 1, 1, 16'h0000, 0, 16'h0000, 0, 0);
    add("t2_ale_r0",     1, 1, 1, 1, 16'h0000, 0, 16'h0000, 1, 0);
    add("t2_rd0",        0, 0, 0, 1, 16'h0000, 1, 16'h0A0A, 1, 0);
    add("t2_rel_r0",     0, 1, 1, 1, 16'h0000, 0, 16'h0000, 0, 0);

    // reset block
    nReset = 1'b0; ALE = 1'b0; nME = 1'b1; nOE = 1'b1; nWE = 1'b1; SysBusIn = 16'h0;
    repeat (3) @(posedge Clock);
    #1;
    chk("reset_outputs", 0, 16'h0000, 0, 0);
    chk_state("reset_state", ST_IDLE);
    n_tests++;
    if (AddrDbg !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_addr: addr=%h required 0000", AddrDbg);
    end
    nReset = 1'b1;

    // table-driven vectors
    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].ale, tbl[i].nme, tbl[i].noe, tbl[i].nwe, tbl[i].din);
      chk(tbl[i].name, tbl[i].oe, tbl[i].dout, tbl[i].busy, tbl[i].err);
      if (tbl[i].name == "t2_miss_rd") chk_state("t2_state_idle", ST_IDLE);
    end

    // held write: only the first strobe edge writes
    cyc(1, 1, 1, 1, 16'h0003);    chk("t3_ale", 0, 16'h0, 1, 0);
    cyc(0, 0, 1, 0, 16'h1111);    chk("t3_wr", 0, 16'h0, 1, 0);
    chk_state("t3_state_write", ST_WRITE);
    cyc(0, 0, 1, 0, 16'h2222);    chk("t3_hold1", 0, 16'h0, 1, 0);
    cyc(0, 0, 1, 0, 16'h2222);    chk("t3_hold2", 0, 16'h0, 1, 0);
    cyc(0, 1, 1, 1, 16'h0000);    chk("t3_rel", 0, 16'h0, 0, 0);
    fetch(16'h0003, 16'h1111);

    // ALE abort during READ
    stw(16'h0005, 16'hA5A5);
    stw(16'h0006, 16'h6666);
    cyc(1, 1, 1, 1, 16'h0005);    chk("t4_ale5", 0, 16'h0, 1, 0);
    cyc(0, 0, 0, 1, 16'h0000);    chk("t4_rd5", 1, 16'hA5A5, 1, 0);
    cyc(1, 1, 1, 1, 16'h0006);    chk("t4_abort", 0, 16'h0, 1, 0);
    chk_state("t4_state_addr", ST_ADDR);
    cyc(0, 0, 0, 1, 16'h0000);    chk("t4_rd6", 1, 16'h6666, 1, 0);
    cyc(0, 1, 1, 1, 16'h0000);    chk("t4_rel", 0, 16'h0, 0, 0);

    // reset during READ
    stw(16'h0009, 16'h5A5A);
    cyc(1, 1, 1, 1, 16'h0009);    chk("t5_ale", 0, 16'h0, 1, 0);
    cyc(0, 0, 0, 1, 16'h0000);    chk("t5_rd", 1, 16'h5A5A, 1, 0);
    nReset = 1'b0;
    cyc(0, 0, 0, 1, 16'h0000);    chk("t5_reset", 0, 16'h0, 0, 0);
    chk_state("t5_state_idle", ST_IDLE);
    nReset = 1'b1;
    cyc(0, 1, 1, 1, 16'h0000);    chk("t5_idle", 0, 16'h0, 0, 0);
    fetch(16'h0009, 16'h5A5A);

    // back-to-back CPU sequences over 0x0000..0x000F
    strict_mon = 1'b1;
    for (int i = 0; i < 16; i++) stw(16'(i), pat(i));
    for (int i = 0; i < 16; i++) begin
      fetch(16'(i), pat(i));
      ldw(16'(15 - i), pat(15 - i));
    end
    strict_mon = 1'b0;

    @(posedge Clock);
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog: the sequence is fixed-length; this only guards against a stall.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
